casez_selector_encoder: RTL and testbench

CASEZ_SELECTOR_ENCODER -- requirements
Module: casez_selector_encoder

---
 rtl/casez_selector_encoder.sv | 82 ++++++++
 tb/tb_casez_selector_encoder.sv | 139 +++++++++++++
 2 files changed

// File: rtl/casez_selector_encoder.sv
// casez_selector_encoder: scans selectors 0..15 for the first one that hits only the requested casez arm and encodes it.
module casez_selector_encoder #(
    parameter logic [1:0] FILL = 2'b00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_code,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [1:0] case_expr,
    output logic [3:0] case_inside_val,
    output logic [4:0] rsp_code,
    output logic       rsp_err,
    output logic [1:0] rsp_overlap
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    state_t     state;
    logic [2:0] code;
    logic [3:0] cnt;
    logic [1:0] ovl, ovl_nxt;
    logic [4:0] hits;
    logic       multi, only_target, bad_code;
    // Arm matches for candidate s = cnt, bit order s[3:0]
    always_comb begin
        hits[0]     = cnt[3] & ~cnt[1];
        hits[1]     = cnt[2:0] == 3'b101;
        hits[2]     = ~cnt[3] & cnt[1];
        hits[3]     = cnt[3] & cnt[1];
        hits[4]     = cnt[2:0] == 3'b111;
        multi       = $countones(hits) > 1;
        bad_code    = code > 3'd4;
        only_target = !bad_code && hits == (5'b00001 << code);
        ovl_nxt     = (multi && ovl != 2'd3) ? ovl + 2'd1 : ovl;
    end
    assign req_ready = state == IDLE;
    assign rsp_valid = state == DONE;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            code            <= '0;
            cnt             <= '0;
            ovl             <= '0;
            case_expr       <= '0;
            case_inside_val <= '0;
            rsp_code        <= '0;
            rsp_err         <= 1'b0;
            rsp_overlap     <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    code  <= req_code;
                    cnt   <= '0;
                    ovl   <= '0;
                    state <= SCAN;
                end
                SCAN: begin
                    ovl <= ovl_nxt;
                    cnt <= cnt + 4'd1;
                    if (only_target) begin
                        case_expr       <= {cnt[0], cnt[3]};
                        case_inside_val <= {cnt[2], cnt[1], FILL};
                        rsp_code        <= 5'd30 + {2'b00, code};
                        rsp_err         <= 1'b0;
                        rsp_overlap     <= ovl_nxt;
                        state           <= DONE;
                    end else if (bad_code || cnt == 4'd15) begin
                        case_expr       <= '0;
                        case_inside_val <= '0;
                        rsp_code        <= '0;
                        rsp_err         <= 1'b1;
                        rsp_overlap     <= bad_code ? 2'd0 : ovl_nxt;
                        state           <= DONE;
                    end
                end
                DONE: if (rsp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_casez_selector_encoder.sv
// tb_casez_selector_encoder: directed checks of the selector encoder against hand-computed vectors.
module tb_casez_selector_encoder;
    logic       clk = 0, rst_n = 0, req_valid = 0, rsp_ready = 0;
    logic [2:0] req_code = 0;
    logic       req_ready, rsp_valid, rsp_err;
    logic [1:0] case_expr, rsp_overlap;
    logic [3:0] case_inside_val;
    logic [4:0] rsp_code;
    int         n_cmp = 0, n_err = 0, lat, arms;
    logic [4:0] dec;

    casez_selector_encoder dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_code(req_code), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .case_expr(case_expr), .case_inside_val(case_inside_val),
        .rsp_code(rsp_code), .rsp_err(rsp_err), .rsp_overlap(rsp_overlap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference casez decoder: first matching arm wins, also counts matching arms
    task automatic decode(input logic [1:0] ce, input logic [3:0] civ, output logic [4:0] val, output int n);
        logic [3:0] s;
        s = {ce[0], civ[3], civ[2], ce[1]};
        n = int'(s ==? 4'b1?0?) + int'(s ==? 4'b?101) + int'(s ==? 4'b0?1?) + int'(s ==? 4'b1?1?) + int'(s ==? 4'b?111);
        casez (s)
            4'b1?0?: val = 5'd30;
            4'b?101: val = 5'd31;
            4'b0?1?: val = 5'd32;
            4'b1?1?: val = 5'd33;
            4'b?111: val = 5'd34;
            default: val = 5'd0;
        endcase
    endtask

    task automatic send(input logic [2:0] c);
        @(negedge clk);
        check("ready_before_req", req_ready, 1);
        req_valid = 1;
        req_code  = c;
        @(posedge clk);
        #1 req_valid = 0;
        lat = 0;
        do begin
            @(posedge clk);
            #1 lat++;
        end while (!rsp_valid && lat < 40);
    endtask

    task automatic consume();
        check("ready_in_done", req_ready, 0);
        rsp_ready = 1;
        @(posedge clk);
        #1 rsp_ready = 0;
        check("valid_after_consume", rsp_valid, 0);
        check("ready_after_consume", req_ready, 1);
    endtask

    task automatic hit(input logic [2:0] c, input int l, input logic [1:0] ce, input logic [3:0] civ,
                       input logic [4:0] rc, input logic [1:0] ov);
        send(c);
        check($sformatf("lat_c%0d", c), lat, l);
        check($sformatf("expr_c%0d", c), case_expr, ce);
        check($sformatf("civ_c%0d", c), case_inside_val, civ);
        check($sformatf("code_c%0d", c), rsp_code, rc);
        check($sformatf("err_c%0d", c), rsp_err, 0);
        check($sformatf("ovl_c%0d", c), rsp_overlap, ov);
        decode(case_expr, case_inside_val, dec, arms);
        check($sformatf("dec_c%0d", c), dec, rsp_code);
        check($sformatf("arms_c%0d", c), arms, 1);
        consume();
    endtask

    initial begin
        #2;
        check("rst_ready", req_ready, 1);
        check("rst_valid", rsp_valid, 0);
        check("rst_code", rsp_code, 0);
        check("rst_vec", {case_expr, case_inside_val}, 0);
        check("rst_err_ovl", {rsp_err, rsp_overlap}, 0);
        @(negedge clk);
        rst_n = 1;

        hit(3'd0, 9, 2'b01, 4'b0000, 5'd30, 2'd1);
        hit(3'd1, 6, 2'b10, 4'b1000, 5'd31, 2'd0);
        hit(3'd2, 3, 2'b00, 4'b0100, 5'd32, 2'd0);
        hit(3'd3, 11, 2'b01, 4'b0100, 5'd33, 2'd1);

        send(3'd4);
        check("lat_c4", lat, 16);
        check("err_c4", rsp_err, 1);
        check("ovl_c4", rsp_overlap, 3);
        check("code_c4", rsp_code, 0);
        check("vec_c4", {case_expr, case_inside_val}, 0);
        consume();

        send(3'd6);
        check("lat_c6", lat, 1);
        check("err_c6", rsp_err, 1);
        check("code_c6", rsp_code, 0);
        req_valid = 1;
        req_code  = 3'd2;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", rsp_valid, 1);
            check("hold_err", rsp_err, 1);
            check("hold_code", rsp_code, 0);
        end
        req_valid = 0;
        consume();

        @(negedge clk);
        req_valid = 1;
        req_code  = 3'd4;
        @(posedge clk);
        #1 req_valid = 0;
        repeat (5) @(posedge clk);
        #2 rst_n = 0;
        #1;
        check("midrst_ready", req_ready, 1);
        check("midrst_valid", rsp_valid, 0);
        check("midrst_outs", {case_expr, case_inside_val, rsp_code, rsp_err, rsp_overlap}, 0);
        @(negedge clk);
        rst_n = 1;
        hit(3'd2, 3, 2'b00, 4'b0100, 5'd32, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
